// File: rtl/nibble_serial_add_ctrl.sv
//============================================================================
// Module   : nibble_serial_add_ctrl
// Brief    : Sequences a WIDTH-bit unsigned add through an external 4-bit
//            adder slice, one nibble per cycle. Operands arrive over a
//            valid/ready handshake, and the result leaves over another.
// Options  : SIGNED_OVERFLOW_EN - adds the ovf output, which flags
//            two's-complement overflow of the full-width sum.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16            // multiple of 4, at least 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic [3:0]       adder_a,
    output logic [3:0]       adder_b,
    output logic             adder_cin,
    input  logic [3:0]       adder_sum,
    input  logic             adder_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_cout,
`ifdef SIGNED_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int BW  = IW + 2;        // bit offset of a nibble inside a word

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    idx_d;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic             cout_q;
    logic [BW-1:0]    base;
    logic             last_nib;
`ifdef SIGNED_OVERFLOW_EN
    logic             ovf_q;
`endif

    assign base     = {idx_q, 2'b00};
    assign idx_d    = idx_q + IW'(1);
    assign last_nib = (idx_q == IW'(NIB - 1));

    // Result word with the current nibble replaced by the adder's sum
    always_comb begin
        result_d             = result_q;
        result_d[base +: 4]  = adder_sum;
    end

    // Adder operands come only from registered state and are zero outside RUN
    always_comb begin
        adder_a   = 4'd0;
        adder_b   = 4'd0;
        adder_cin = 1'b0;
        if (state_q == S_RUN) begin
            adder_a   = a_q[base +: 4];
            adder_b   = b_q[base +: 4];
            adder_cin = carry_q;
        end
    end

    // Control FSM: accept operands, walk the nibbles, then hold the result until it is taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
`ifdef SIGNED_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= op_a;
                        b_q        <= op_b;
                        carry_q    <= op_cin;
                        idx_q      <= '0;
                        result_q   <= '0;
                        cout_q     <= 1'b0;
`ifdef SIGNED_OVERFLOW_EN
                        ovf_q      <= 1'b0;
`endif
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    result_q <= result_d;
                    carry_q  <= adder_cout;
                    if (last_nib) begin
                        idx_q       <= '0;
                        cout_q      <= adder_cout;
`ifdef SIGNED_OVERFLOW_EN
                        // Like-signed operands whose sum changes sign have overflowed
                        ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (adder_sum[3] != a_q[WIDTH-1]);
`endif
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                S_DONE: begin
                    // IDLE is entered before any new accept, which leaves a one-cycle bubble
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign result      = result_q;
    assign result_cout = cout_q;
`ifdef SIGNED_OVERFLOW_EN
    assign ovf         = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
//============================================================================
// Module   : tb_nibble_serial_add_ctrl
// Brief    : Directed self-checking bench for nibble_serial_add_ctrl with a
//            behavioural 4-bit adder on the adder port. It also runs the
//            overflow test when SIGNED_OVERFLOW_EN is defined.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nibble_serial_add_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [3:0]       adder_a;
    logic [3:0]       adder_b;
    logic             adder_cin;
    logic [3:0]       adder_sum;
    logic             adder_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             result_cout;
    logic             busy;
`ifdef SIGNED_OVERFLOW_EN
    logic             ovf;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_cin      (op_cin),
        .adder_a     (adder_a),
        .adder_b     (adder_b),
        .adder_cin   (adder_cin),
        .adder_sum   (adder_sum),
        .adder_cout  (adder_cout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_cout (result_cout),
`ifdef SIGNED_OVERFLOW_EN
        .ovf         (ovf),
`endif
        .busy        (busy)
    );

    // Behavioural stand-in for the external 4-bit ripple adder
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {4'd0, adder_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one accept edge, scramble them afterwards, and wait for out_valid
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         output int lat);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_cin   = cin;
        tick();
        in_valid = 1'b0;
        op_a     = 16'($urandom);
        op_b     = 16'($urandom);
        op_cin   = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_flags: {in_ready,out_valid,busy}=%b expected 100", {in_ready, out_valid, busy});
        end
        tests_run++;
        if ({result_cout, result} !== 17'h0) begin
            tests_failed++;
            $display("FAIL reset_result: {cout,result}=%h expected 0", {result_cout, result});
        end
        tests_run++;
        if ({adder_a, adder_b, adder_cin} !== 9'h0) begin
            tests_failed++;
            $display("FAIL reset_adder_drive: a=%h b=%h cin=%b expected 0", adder_a, adder_b, adder_cin);
        end
`ifdef SIGNED_OVERFLOW_EN
        tests_run++;
        if (ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ovf: ovf=%b expected 0", ovf);
        end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_add();
        int lat;
        do_op(16'h1234, 16'h4321, 1'b0, lat);
        tests_run++;
        if (lat !== 4) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d cycles expected 4", lat);
        end
        tests_run++;
        if ({result_cout, result} !== 17'h05555) begin
            tests_failed++;
            $display("FAIL basic_sum: {cout,result}=%h expected 05555", {result_cout, result});
        end
        tests_run++;
        if ({in_ready, busy} !== 2'b01) begin
            tests_failed++;
            $display("FAIL basic_done_flags: {in_ready,busy}=%b expected 01", {in_ready, busy});
        end
        consume();
        tests_run++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            tests_failed++;
            $display("FAIL basic_release: {in_ready,out_valid,busy}=%b expected 100", {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_carry_ripple();
        logic [3:0] exp_b;
        logic       exp_cin;
        in_valid = 1'b1;
        op_a     = 16'hFFFF;
        op_b     = 16'h0001;
        op_cin   = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_b   = (i == 0) ? 4'h1 : 4'h0;
            exp_cin = (i == 0) ? 1'b0 : 1'b1;
            tests_run++;
            if ({adder_a, adder_b, adder_cin} !== {4'hF, exp_b, exp_cin}) begin
                tests_failed++;
                $display("FAIL ripple_drive_nib%0d: a=%h b=%h cin=%b expected F %h %b",
                         i, adder_a, adder_b, adder_cin, exp_b, exp_cin);
            end
            tick();
        end
        tests_run++;
        if ({out_valid, result_cout, result} !== 18'h30000) begin
            tests_failed++;
            $display("FAIL ripple_sum: {valid,cout,result}=%h expected 30000", {out_valid, result_cout, result});
        end
        tests_run++;
        if ({adder_a, adder_b, adder_cin} !== 9'h0) begin
            tests_failed++;
            $display("FAIL ripple_idle_drive: a=%h b=%h cin=%b expected 0 outside RUN", adder_a, adder_b, adder_cin);
        end
        consume();
    endtask

    task automatic test_cin_only();
        int lat;
        do_op(16'h0000, 16'h0000, 1'b1, lat);
        tests_run++;
        if ({lat[3:0], result_cout, result} !== {4'd4, 17'h00001}) begin
            tests_failed++;
            $display("FAIL cin_only: lat=%0d {cout,result}=%h expected lat 4 and 00001", lat, {result_cout, result});
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        do_op(16'h00F0, 16'h0F10, 1'b0, lat);
        // Stray operands offered while DONE must be ignored
        in_valid = 1'b1;
        op_a     = 16'h1111;
        op_b     = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({out_valid, in_ready, result_cout, result} !== {2'b10, 17'h01000}) begin
                tests_failed++;
                $display("FAIL backpressure_hold_%0d: valid=%b ready=%b {cout,result}=%h expected 1 0 01000",
                         i, out_valid, in_ready, {result_cout, result});
            end
            tick();
        end
        in_valid = 1'b0;
        consume();
        tests_run++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            tests_failed++;
            $display("FAIL backpressure_release: {in_ready,out_valid,busy}=%b expected 100", {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        in_valid = 1'b1;
        op_a     = 16'hAAAA;
        op_b     = 16'h5555;
        op_cin   = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({adder_a, adder_b, busy} !== {4'hA, 4'h5, 1'b1}) begin
            tests_failed++;
            $display("FAIL midrun_before_reset: a=%h b=%h busy=%b expected A 5 1", adder_a, adder_b, busy);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests_run++;
        if ({out_valid, in_ready, busy, result_cout, result} !== {3'b010, 17'h0}) begin
            tests_failed++;
            $display("FAIL midrun_abort: valid=%b ready=%b busy=%b {cout,result}=%h expected 0 1 0 0",
                     out_valid, in_ready, busy, {result_cout, result});
        end
        do_op(16'h0001, 16'h0001, 1'b0, lat);
        tests_run++;
        if ({lat[3:0], result_cout, result} !== {4'd4, 17'h00002}) begin
            tests_failed++;
            $display("FAIL midrun_recover: lat=%0d {cout,result}=%h expected lat 4 and 00002", lat, {result_cout, result});
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int  n_valid;
        bit  prev_valid;
        in_valid  = 1'b1;
        op_a      = 16'h0102;
        op_b      = 16'h0304;
        op_cin    = 1'b0;
        out_ready = 1'b1;
        n_valid    = 0;
        prev_valid = 1'b0;
        // One result per six cycles: accept, four RUN edges, and one DONE edge
        for (int i = 0; i < 18; i++) begin
            tick();
            if (out_valid) begin
                n_valid++;
                tests_run++;
                if ({prev_valid, result_cout, result} !== {1'b0, 17'h00406}) begin
                    tests_failed++;
                    $display("FAIL b2b_result_cyc%0d: prev_valid=%b {cout,result}=%h expected 0 00406",
                             i, prev_valid, {result_cout, result});
                end
            end
            prev_valid = out_valid;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tests_run++;
        if (n_valid !== 3) begin
            tests_failed++;
            $display("FAIL b2b_throughput: got %0d results in 18 cycles expected 3", n_valid);
        end
        tick();
        tests_run++;
        if ({in_ready, busy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL b2b_idle: {in_ready,busy}=%b expected 10", {in_ready, busy});
        end
    endtask

`ifdef SIGNED_OVERFLOW_EN
    task automatic test_overflow();
        int lat;
        do_op(16'h7FFF, 16'h0001, 1'b0, lat);
        tests_run++;
        if ({ovf, result_cout, result} !== {1'b1, 17'h08000}) begin
            tests_failed++;
            $display("FAIL ovf_pos: ovf=%b {cout,result}=%h expected 1 08000", ovf, {result_cout, result});
        end
        consume();
        do_op(16'hFFFF, 16'h0001, 1'b0, lat);
        tests_run++;
        if ({ovf, result_cout, result} !== {1'b0, 17'h10000}) begin
            tests_failed++;
            $display("FAIL ovf_mixed: ovf=%b {cout,result}=%h expected 0 10000", ovf, {result_cout, result});
        end
        consume();
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_cin    = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic_add();
        test_carry_ripple();
        test_cin_only();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SIGNED_OVERFLOW_EN
        test_overflow();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
